iob_fifo_stream_reader: RTL

Read-side controller for `iob_sync_fifo`. It drains the FIFO through its `read_en`/`data_out`/`empty` port and presents the words on a valid/ready stream with back-pressure. A 2-entry output buffer with in-flight accounting sustains one word per cycle for both FIFO read latencies: register-file FIFO (`USE_RAM=0`, zero latency) and RAM FIFO (`USE_RAM=1`, one-cycle latency). It sits between any `iob_sync_fifo` instance and a downstream stream consumer.

---
 rtl/iob_fifo_stream_reader.sv | 95 +++++++++
 1 files changed

// File: rtl/iob_fifo_stream_reader.sv
// Read-side controller for iob_sync_fifo: drains the FIFO into a 2-entry buffer
// and presents the words on a valid/ready stream, for both FIFO read latencies.
module iob_fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int USE_RAM    = 0,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_W-1:0]      xfer_cnt
);

  logic [1:0]            buf_cnt_q, buf_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pop;
  logic                  capture;
  logic [2:0]            occupancy;

  assign pop       = (buf_cnt_q != 2'd0) & m_ready;
  assign occupancy = {1'b0, buf_cnt_q} + {2'b00, inflight_q};

  // Words already buffered or on their way must leave room for the next read,
  // counting the slot freed by a transfer happening this same cycle.
  assign fifo_read_en = rst & ~clr & ~fifo_empty & (occupancy < (3'd2 + {2'b00, pop}));

  assign capture = (USE_RAM != 0) ? inflight_q : fifo_read_en;

  always_comb begin
    buf_cnt_d  = buf_cnt_q;
    head_d     = head_q;
    tail_d     = tail_q;
    inflight_d = (USE_RAM != 0) & fifo_read_en;
    cnt_d      = pop ? cnt_q + CNT_W'(1) : cnt_q;
    if (clr) begin
      buf_cnt_d = 2'd0;
    end else begin
      case ({pop, capture})
        2'b10: begin
          head_d    = tail_q;
          buf_cnt_d = buf_cnt_q - 2'd1;
        end
        2'b01: begin
          if (buf_cnt_q == 2'd0) begin
            head_d = fifo_data;
          end else begin
            tail_d = fifo_data;
          end
          buf_cnt_d = buf_cnt_q + 2'd1;
        end
        2'b11: begin
          // With a single buffered word the incoming word replaces it as head.
          if (buf_cnt_q == 2'd1) begin
            head_d = fifo_data;
          end else begin
            head_d = tail_q;
            tail_d = fifo_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_cnt_q  <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
    end else begin
      buf_cnt_q  <= buf_cnt_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
    end
  end

  assign m_valid  = (buf_cnt_q != 2'd0);
  assign m_data   = head_q;
  assign xfer_cnt = cnt_q;

endmodule
